mult_iter: RTL and testbench
============================

# mult_iter

Iterative 32x32 shift-add multiplier for the EX stage. It is the arithmetic counterpart of the iterative divider and uses the same start/finish handshake toward the EX/control logic. Signed or unsigned operands are supported. The 64-bit product is delivered after a fixed 35-cycle latency, or 3 cycles when either operand is zero.

## Interface

Parameters:
- none; widths are fixed at 32-bit operands and a 64-bit product.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request. The requester holds it high until it has consumed `finish`, then drops it.
- `sign`  in  1  1 = signed (two's complement) operands; 0 = unsigned. Sampled with the operands.
- `multiplicand_i`  in  32  operand A, sampled on the accepting edge.
- `multiplier_i`  in  32  operand B, sampled on the accepting edge.
- `finish`  out  1  product valid.
- `result`  out  64  product; `result[63:32]` is the high word, `result[31:0]` the low word.

## Operation

States:
- MulFree: idle.
- MulZero: either operand is zero.
- MulOn: iterating.
- MulEnd: result presented.

MulFree:
- `finish` = 0 and `result` = 0.
- On an edge with `start` = 1:
  - Latch `sign` and the two operand sign bits (A[31], B[31]). Later cycles never re-read the inputs.
  - If either operand is 0, go to MulZero.
  - Otherwise:
    - Latch mcand = |A| and mplier = |B|. The absolute value is taken only when `sign` = 1 and the operand is negative, computed as ~x+1 in 32-bit unsigned. 0x80000000 therefore stays 0x80000000.
    - Clear the accumulator acc[63:0].
    - Set count = 0.
    - Go to MulOn.

MulZero:
- Set acc = 0 and go to MulEnd.

MulOn with count != 32 (one iteration per edge):
- Form sum[32:0] = {1'b0, acc[63:32]} + (mplier[0] ? {1'b0, mcand} : 33'd0).
- Update acc <= {sum[32:0], acc[31:1]}.
- Shift mplier right by 1.
- count <= count + 1.

MulOn with count == 32:
- If the latched sign = 1 and A[31] ^ B[31] = 1, set acc <= ~acc + 1 (64-bit negation).
- Go to MulEnd and set count = 0.

MulEnd:
- `result` <= acc and `finish` <= 1.
- If `start` = 0 on the same edge, that assignment is overridden: go to MulFree with `finish` = 0 and `result` = 0.

Boundary rules:
- Abort: `start` = 0 on any edge while in MulOn or MulZero returns the block to MulFree. `finish` stays 0 and `result` stays 0. No product is delivered.
- Back-to-back operations: a new operation is accepted only from MulFree. At least one cycle with `start` low is therefore required between operations.
- Operand changes after acceptance have no effect.
- Overflow cannot occur; the 64-bit product is exact for all inputs.
- `rst` low at any time, including mid-operation:
  - Immediately forces MulFree, `finish` = 0, `result` = 0, count = 0, acc = 0.
  - No clock edge is required.
  - The first edge after `rst` rises can accept a new operation.

## Timing

Edge numbering: E0 is the edge that samples `start` = 1 in MulFree.

Non-zero operands:
- E1..E32: iterations.
- E33: sign fix and transition to MulEnd.
- E34: `result` and `finish` registered.
- `finish` = 1 is visible from after E34 until the first edge in MulEnd that sees `start` = 0. The cycle after that edge shows `finish` = 0 and `result` = 0.

Zero operand:
- E1: MulZero to MulEnd.
- E2: `finish` = 1, `result` = 0.

Output registers:
- `finish` and `result` are registered outputs; there is no combinational input-to-output path.
- `result` is stable for as long as `finish` = 1.

## Test plan

- Unsigned 3 x 5 with `start` held high → `finish` rises after E34, `result` = 0x00000000_0000000F, and holds while `start` stays high. Dropping `start` → `finish` = 0 and `result` = 0 one edge later.
- Signed 0xFFFFFFFD x 0x00000005 → `result` = 0xFFFFFFFF_FFFFFFF1. The same operands with `sign` = 0 → 0x00000004_FFFFFFF1.
- Extremes:
  - Signed 0x80000000 x 0x80000000 → 0x40000000_00000000.
  - Signed 0x80000000 x 0x00000001 → 0xFFFFFFFF_80000000.
  - Unsigned 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFE_00000001.
- Zero operand: signed 0 x 0xFFFFFFFF → `finish` after E2, `result` = 0. Change the operands during E1 → no effect.
- Abort and reset:
  - Drop `start` at E10 → back to MulFree, `finish` never rises.
  - Assert `rst` low mid-cycle during iteration 20 → `finish` and `result` are 0 immediately.
  - A fresh 7 x 6 operation afterwards → 42 at E34.
- Random signed and unsigned operand pairs (at least 1000) with random `start`-drop delays after `finish` → every product matches the reference model. Latency is exactly 34 edges for non-zero operands and 2 edges for zero operands.

Source files
------------

// File: rtl/mult_iter_if.sv
// ============================================================================
// Module   : mult_iter_if
// Purpose  : start/finish handshake and operand/product bus for mult_iter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_iter_if;
    logic        start;
    logic        sign;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic        finish;
    logic [63:0] result;

    modport master (
        output start, sign, multiplicand_i, multiplier_i,
        input  finish, result
    );

    modport slave (
        input  start, sign, multiplicand_i, multiplier_i,
        output finish, result
    );
endinterface

`default_nettype wire

// File: rtl/mult_iter.sv
// ============================================================================
// Module   : mult_iter
// Purpose  : iterative 32x32 shift-add multiplier, signed or unsigned,
//            35-cycle latency (3 cycles when an operand is zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_iter (
    input  wire logic   clk,
    input  wire logic   rst,
    mult_iter_if.slave  bus
);

    typedef enum logic [1:0] {
        MUL_FREE = 2'd0,
        MUL_ZERO = 2'd1,
        MUL_ON   = 2'd2,
        MUL_END  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_sign;
    logic        r_a_neg;
    logic        r_b_neg;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_acc;
    logic [5:0]  r_count;
    logic        r_finish;
    logic [63:0] r_result;

    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_sum;

    // Magnitudes wrap for 0x80000000, which is still correct as an unsigned magnitude.
    always_comb begin
        w_abs_a = (bus.sign && bus.multiplicand_i[31]) ? (~bus.multiplicand_i + 32'd1)
                                                       : bus.multiplicand_i;
        w_abs_b = (bus.sign && bus.multiplier_i[31])   ? (~bus.multiplier_i + 32'd1)
                                                       : bus.multiplier_i;
        w_sum   = {1'b0, r_acc[63:32]} + (r_mplier[0] ? {1'b0, r_mcand} : 33'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= MUL_FREE;
            r_sign   <= 1'b0;
            r_a_neg  <= 1'b0;
            r_b_neg  <= 1'b0;
            r_mcand  <= 32'd0;
            r_mplier <= 32'd0;
            r_acc    <= 64'd0;
            r_count  <= 6'd0;
            r_finish <= 1'b0;
            r_result <= 64'd0;
        end else begin
            case (r_state)
                MUL_FREE: begin
                    r_finish <= 1'b0;
                    r_result <= 64'd0;
                    if (bus.start) begin
                        r_sign  <= bus.sign;
                        r_a_neg <= bus.multiplicand_i[31];
                        r_b_neg <= bus.multiplier_i[31];
                        if (bus.multiplicand_i == 32'd0 || bus.multiplier_i == 32'd0) begin
                            r_state <= MUL_ZERO;
                        end else begin
                            r_mcand  <= w_abs_a;
                            r_mplier <= w_abs_b;
                            r_acc    <= 64'd0;
                            r_count  <= 6'd0;
                            r_state  <= MUL_ON;
                        end
                    end
                end

                MUL_ZERO: begin
                    if (!bus.start) begin
                        r_state <= MUL_FREE;
                    end else begin
                        r_acc   <= 64'd0;
                        r_state <= MUL_END;
                    end
                end

                MUL_ON: begin
                    if (!bus.start) begin
                        r_state <= MUL_FREE;
                    end else if (r_count != 6'd32) begin
                        r_acc    <= {w_sum, r_acc[31:1]};
                        r_mplier <= {1'b0, r_mplier[31:1]};
                        r_count  <= r_count + 6'd1;
                    end else begin
                        // Product of magnitudes is restored to two's complement here.
                        if (r_sign && (r_a_neg ^ r_b_neg))
                            r_acc <= ~r_acc + 64'd1;
                        r_count <= 6'd0;
                        r_state <= MUL_END;
                    end
                end

                MUL_END: begin
                    if (!bus.start) begin
                        r_finish <= 1'b0;
                        r_result <= 64'd0;
                        r_state  <= MUL_FREE;
                    end else begin
                        r_finish <= 1'b1;
                        r_result <= r_acc;
                    end
                end

                default: r_state <= MUL_FREE;
            endcase
        end
    end

    assign bus.finish = r_finish;
    assign bus.result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mult_iter.sv
// ============================================================================
// Module   : tb_mult_iter
// Purpose  : scoreboard bench for mult_iter (directed vectors plus a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_iter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mult_iter_if bus ();

    mult_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        prev_fin = 1'b0;
    logic [63:0] held   = 64'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each rising finish and checks stability while held.
    always @(negedge clk) begin
        if (rst && bus.finish) begin
            if (!prev_fin) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_finish: finish=1 result=%h, required no finish", bus.result);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (bus.result !== e.res || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL product: result=%h at cycle %0d, required %h at cycle %0d",
                                 bus.result, cyc, e.res, e.cyc);
                    end
                end
                held = bus.result;
            end else begin
                checks++;
                if (bus.result !== held) begin
                    errors++;
                    $display("FAIL result_stable: result=%h, required %h", bus.result, held);
                end
            end
        end
        prev_fin = rst ? bus.finish : 1'b0;
    end

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic sg);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (sg) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check_idle(input string name);
        checks++;
        if (bus.finish !== 1'b0 || bus.result !== 64'd0) begin
            errors++;
            $display("FAIL %s: finish=%b result=%h, required finish=0 result=0", name, bus.finish, bus.result);
        end
    endtask

    task automatic wait_finish();
        int n = 0;
        while (bus.finish !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (bus.finish !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL finish_timeout: finish=%b after %0d cycles, required 1", bus.finish, n);
            if (q.size() > 0) void'(q.pop_front());
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [63:0] exp, input int hold, input bit scramble);
        exp_t e;
        @(negedge clk);
        bus.start          = 1'b1;
        bus.sign           = sg;
        bus.multiplicand_i = a;
        bus.multiplier_i   = b;
        e.res = exp;
        e.cyc = cyc + 1 + ((a == 32'd0 || b == 32'd0) ? 2 : 34);
        q.push_back(e);
        @(negedge clk);
        if (scramble) begin
            bus.multiplicand_i = $urandom;
            bus.multiplier_i   = $urandom | 32'd1;
            bus.sign           = ~sg;
        end
        wait_finish();
        repeat (hold) @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check_idle("drop_start");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        bit          saw;

        bus.start          = 1'b0;
        bus.sign           = 1'b0;
        bus.multiplicand_i = 32'd0;
        bus.multiplier_i   = 32'd0;

        repeat (3) @(negedge clk);
        check_idle("reset_state");
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        run_op(32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, 4, 1'b0);
        run_op(32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 1, 1'b0);
        run_op(32'hFFFFFFFD, 32'd5, 1'b0, 64'h00000004_FFFFFFF1, 0, 1'b0);
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 2, 1'b0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, 0, 1'b0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1, 1'b0);
        run_op(32'd0, 32'hFFFFFFFF, 1'b1, 64'd0, 2, 1'b1);
        run_op(32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 64'h00000000_0000002A, 0, 1'b1);

        // Abort: start drops on E10 of an iteration.
        @(negedge clk);
        bus.start = 1'b1; bus.sign = 1'b0;
        bus.multiplicand_i = 32'd1234; bus.multiplier_i = 32'd5678;
        repeat (10) @(negedge clk);
        bus.start = 1'b0;
        saw = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (bus.finish) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL abort: finish rose=1, required 0");
        end

        // Asynchronous reset during iteration 20.
        @(negedge clk);
        bus.start = 1'b1; bus.sign = 1'b1;
        bus.multiplicand_i = 32'h12345678; bus.multiplier_i = 32'h9;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_idle("reset_mid_iter");
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_idle("after_reset_mid_iter");

        // Asynchronous reset while the product is presented.
        @(negedge clk);
        bus.start = 1'b1; bus.sign = 1'b0;
        bus.multiplicand_i = 32'h10; bus.multiplier_i = 32'h10;
        begin
            exp_t e;
            e.res = 64'h100;
            e.cyc = cyc + 1 + 34;
            q.push_back(e);
        end
        @(negedge clk);
        wait_finish();
        #1 rst = 1'b0;
        #1 check_idle("reset_mid_end");
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b1;

        run_op(32'd7, 32'd6, 1'b0, 64'd42, 1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'd0;
            if ($urandom_range(0, 15) == 0) b = 32'd0;
            sg = 1'($urandom_range(0, 1));
            run_op(a, b, sg, ref_mul(a, b, sg), int'($urandom_range(0, 3)), 1'b0);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
